// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the double-buffered frame memory port between display reads and raster writes
// and sequences bank swaps on vsync.
module fb_port_arbiter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 20,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rast_wr_en,
    input  logic [9:0]        rast_x,
    input  logic [9:0]        rast_y,
    input  logic [2:0]        rast_color,
    input  logic              raster_done,
    output logic              rast_ready,
    input  logic              disp_rd_req,
    input  logic [9:0]        disp_x,
    input  logic [9:0]        disp_y,
    input  logic              vsync,
    output logic              disp_rd_valid,
    output logic [2:0]        disp_color,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic              front_bank,
    output logic              swap_pending,
    output logic              frame_swapped,
    output logic [DROP_W-1:0] drop_cnt
);
    typedef enum logic {DRAWING, WAIT_SWAP} state_t;
    localparam logic [ADDR_W-1:0] BANK_OFF = ADDR_W'(H_RES * V_RES);
    state_t state, state_nx;
    logic toggle, rd_in, wr_in, wr_go, rd_p1, rd_ok_p1, rd_ok;
    function automatic logic [ADDR_W-1:0] addr_of(input logic bank, input logic [9:0] x, input logic [9:0] y);
        return (bank ? BANK_OFF : '0) + ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction
    always_comb begin
        toggle     = vsync & (state == WAIT_SWAP | raster_done);
        state_nx   = (state == WAIT_SWAP) ? (vsync ? DRAWING : WAIT_SWAP)
                                          : ((raster_done & ~vsync) ? WAIT_SWAP : DRAWING);
        rast_ready = rst & (state == DRAWING) & ~disp_rd_req & ~raster_done;
        rd_in      = (int'(disp_x) < H_RES) & (int'(disp_y) < V_RES);
        wr_in      = (int'(rast_x) < H_RES) & (int'(rast_y) < V_RES);
        wr_go      = rast_wr_en & rast_ready & wr_in;
    end
    assign swap_pending = (state == WAIT_SWAP);
    // read data arrives the cycle after the strobe, so colour is muxed straight from the memory bus
    assign disp_color   = rd_ok ? mem_rdata : 3'b000;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= DRAWING;
            front_bank    <= 1'b0;
            frame_swapped <= 1'b0;
            drop_cnt      <= '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            rd_p1         <= 1'b0;
            rd_ok_p1      <= 1'b0;
            rd_ok         <= 1'b0;
            disp_rd_valid <= 1'b0;
        end else begin
            state         <= state_nx;
            front_bank    <= front_bank ^ toggle;
            frame_swapped <= toggle;
            mem_en        <= disp_rd_req ? rd_in : wr_go;
            mem_we        <= wr_go;
            if (disp_rd_req & rd_in)
                mem_addr <= addr_of(front_bank, disp_x, disp_y);
            else if (wr_go) begin
                mem_addr  <= addr_of(~front_bank, rast_x, rast_y);
                mem_wdata <= rast_color;
            end
            if (rast_wr_en & rast_ready & ~wr_in & ~&drop_cnt)
                drop_cnt <= drop_cnt + 1'b1;
            rd_p1         <= disp_rd_req;
            rd_ok_p1      <= disp_rd_req & rd_in;
            disp_rd_valid <= rd_p1;
            rd_ok         <= rd_ok_p1;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: table-driven vectors plus hand sequences, checked against a cycle model
// through queues of expected memory strobes and display read returns.
module tb_fb_port_arbiter;
    localparam int H = 640, V = 480, AW = 20, DW = 4;
    logic clk = 0, rst = 0;
    logic rast_wr_en = 0, raster_done = 0, disp_rd_req = 0, vsync = 0;
    logic [9:0] rast_x = 0, rast_y = 0, disp_x = 0, disp_y = 0;
    logic [2:0] rast_color = 0, mem_rdata = 0, disp_color, mem_wdata;
    logic rast_ready, disp_rd_valid, mem_en, mem_we, front_bank, swap_pending, frame_swapped;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] drop_cnt;

    fb_port_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DROP_W(DW)) dut (
        .clk(clk), .rst(rst), .rast_wr_en(rast_wr_en), .rast_x(rast_x), .rast_y(rast_y),
        .rast_color(rast_color), .raster_done(raster_done), .rast_ready(rast_ready),
        .disp_rd_req(disp_rd_req), .disp_x(disp_x), .disp_y(disp_y), .vsync(vsync),
        .disp_rd_valid(disp_rd_valid), .disp_color(disp_color), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .front_bank(front_bank),
        .swap_pending(swap_pending), .frame_swapped(frame_swapped), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] hash(input logic [AW-1:0] a);
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9];
    endfunction
    function automatic logic [AW-1:0] addr(input logic b, input int x, input int y);
        return AW'((b ? H * V : 0) + y * H + x);
    endfunction

    // memory model: returns an address-dependent colour one cycle after a read strobe
    always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= hash(mem_addr);

    typedef struct {logic en, we; logic [AW-1:0] a; logic [2:0] wd;} mem_t;
    typedef struct {logic v; logic [2:0] c;} rd_t;
    typedef struct {logic rd; int dx, dy; logic wr; int x, y; logic [2:0] c; logic done, vs, rdy;} vec_t;
    mem_t mq[$];
    rd_t  rq[$];
    int n = 0, nf = 0;
    logic mw, mb, tg;
    logic [DW-1:0] md;
    logic [AW-1:0] ea;
    logic [2:0] ew;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 0; rast_wr_en = 0; raster_done = 0; disp_rd_req = 0; vsync = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rast_ready, 0);
        chk("rst_bank", front_bank, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_valid", disp_rd_valid, 0);
        @(negedge clk);
        rst = 1;
        mw = 0; mb = 0; md = 0; ea = 0; ew = 0;
        mq.delete(); rq.delete();
        rq.push_back('{1'b0, 3'd0});
    endtask

    task automatic step(input logic rd, input int dx, input int dy, input logic wr, input int x, input int y,
                        input logic [2:0] c, input logic done, input logic vs);
        logic er, rin, win, acc;
        mem_t m;
        rd_t r;
        disp_rd_req = rd; disp_x = 10'(dx); disp_y = 10'(dy);
        rast_wr_en = wr; rast_x = 10'(x); rast_y = 10'(y); rast_color = c;
        raster_done = done; vsync = vs;
        #1;
        er = ~mw & ~rd & ~done;
        chk("rast_ready", rast_ready, er);
        rin = dx < H && dy < V;
        win = x < H && y < V;
        acc = wr & er;
        if (rd) begin
            if (rin) ea = addr(mb, dx, dy);
            mq.push_back('{rin, 1'b0, ea, ew});
            rq.push_back('{1'b1, rin ? hash(addr(mb, dx, dy)) : 3'd0});
        end else begin
            if (acc && win) begin ea = addr(~mb, x, y); ew = c; end
            mq.push_back('{acc & win, acc & win, ea, ew});
            rq.push_back('{1'b0, 3'd0});
        end
        if (acc && !win && !(&md)) md++;
        tg = mw ? vs : (done & vs);
        mw = mw ? ~vs : (done & ~vs);
        mb ^= tg;
        @(posedge clk);
        #1;
        m = mq.pop_front();
        r = rq.pop_front();
        chk("mem_en", mem_en, m.en);
        chk("mem_we", mem_we, m.we);
        chk("mem_addr", mem_addr, m.a);
        chk("mem_wdata", mem_wdata, m.wd);
        chk("rd_valid", disp_rd_valid, r.v);
        if (r.v) chk("disp_color", disp_color, r.c);
        chk("front_bank", front_bank, mb);
        chk("swap_pending", swap_pending, mw);
        chk("frame_swapped", frame_swapped, tg);
        chk("drop_cnt", drop_cnt, md);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1},
            '{0, 0, 0, 1, 5, 2, 3'b101, 0, 0, 1},
            '{1, 5, 2, 1, 7, 7, 3'b011, 0, 0, 0},
            '{0, 0, 0, 1, 7, 7, 3'b011, 0, 0, 1},
            '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0},
            '{1, 639, 479, 0, 0, 0, 0, 0, 0, 0},
            '{1, 123, 45, 0, 0, 0, 0, 0, 0, 0},
            '{1, 640, 0, 0, 0, 0, 0, 0, 0, 0},
            '{1, 17, 300, 0, 0, 0, 0, 0, 0, 0},
            '{0, 0, 0, 1, 640, 0, 3'b111, 0, 0, 1},
            '{0, 0, 0, 1, 0, 480, 3'b111, 0, 0, 1},
            '{0, 0, 0, 1, 639, 479, 3'b110, 0, 0, 1},
            '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1},
            '{0, 0, 0, 1, 1, 1, 3'b001, 0, 0, 1}
        };
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].dx, tbl[i].dy, tbl[i].wr, tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].done, tbl[i].vs);
            chk("tbl_ready", rast_ready | 1'b0, rast_ready);
        end
        // deferred swap: raster_done, ten held-off cycles with a pending write, then vsync
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 3, 3, 3'b010, i == 4, 0);
        step(0, 0, 0, 1, 3, 3, 3'b010, 0, 1);
        chk("bank_after_swap", front_bank, 1);
        step(0, 0, 0, 1, 3, 3, 3'b010, 0, 0);
        step(1, 5, 2, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // done together with vsync swaps immediately, read in that cycle uses the old bank
        step(1, 9, 9, 0, 0, 0, 0, 1, 1);
        chk("bank_same_cycle", front_bank, 0);
        step(1, 9, 9, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // drop counter saturation
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 700, i, 0, 0, 0);
        chk("drop_sat", drop_cnt, (1 << DW) - 1);
        // reset mid-flight: pending swap cancelled, in-flight read lost
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        disp_rd_req = 1; disp_x = 4; disp_y = 4;
        @(posedge clk);
        #2;
        rst = 0;
        #1;
        chk("mid_rst_valid", disp_rd_valid, 0);
        chk("mid_rst_bank", front_bank, 0);
        chk("mid_rst_pending", swap_pending, 0);
        chk("mid_rst_ready", rast_ready, 0);
        do_reset();
        step(0, 0, 0, 1, 5, 2, 3'b101, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n, nf);
        $finish;
    end
endmodule
